// File: rtl/mem_master_pkg.sv
// Shared definitions for the near-memory bus master: FSM states and bus defaults.
package mem_master_pkg;

  typedef enum logic [1:0] {
    MM_IDLE  = 2'd0,
    MM_ISSUE = 2'd1,
    MM_WAIT  = 2'd2
  } mm_state_t;

  localparam int MM_DATA_WIDTH    = 32;
  localparam int MM_ADDRESS_WIDTH = 8;
  localparam int MM_TIMEOUT       = 16;

  // Wait counter must be able to hold TIMEOUT itself.
  function automatic int mm_cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_master.sv
// Single-word bus initiator: runs one read/write per request on the shared
// sel/w_en/address_bus/data_bus/mem_ready bus, with a watchdog abort.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int DATA_WIDTH    = MM_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = MM_ADDRESS_WIDTH,
  parameter int TIMEOUT       = MM_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err,
  output logic                     sel,
  output logic                     w_en,
  output logic [ADDRESS_WIDTH-1:0] address_bus,
  inout  wire  [DATA_WIDTH-1:0]    data_bus,
  input  logic                     mem_ready
);

  localparam int            CW       = mm_cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  mm_state_t             state, state_n;
  logic                  accept, complete, abort, cnt_clr, cnt_inc;
  logic [CW-1:0]         wait_cnt;
  logic [DATA_WIDTH-1:0] wdata_q;

  assign req_ready = (state == MM_IDLE);

  // Master drives the data bus only while a write is selected.
  assign data_bus = (sel && w_en) ? wdata_q : {DATA_WIDTH{1'bz}};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MM_IDLE;
    else     state <= state_n;
  end

  // Next-state and control strobes; mem_ready is only honoured in WAIT.
  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    unique case (state)
      MM_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_n = MM_ISSUE;
        end
      end
      MM_ISSUE: begin
        cnt_clr = 1'b1;
        state_n = MM_WAIT;
      end
      MM_WAIT: begin
        if (mem_ready) begin
          complete = 1'b1;
          state_n  = MM_IDLE;
        end else if (wait_cnt == CNT_LAST) begin
          abort   = 1'b1;
          state_n = MM_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_n = MM_IDLE;
    endcase
  end

  // Bus command registers: captured at acceptance, held stable while sel is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel         <= 1'b0;
      w_en        <= 1'b0;
      address_bus <= '0;
      wdata_q     <= '0;
    end else if (accept) begin
      sel         <= 1'b1;
      w_en        <= req_we;
      address_bus <= req_addr;
      wdata_q     <= req_wdata;
    end else if (complete || abort) begin
      sel         <= 1'b0;
    end
  end

  // Watchdog counter of WAIT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          wait_cnt <= '0;
    else if (cnt_clr) wait_cnt <= '0;
    else if (cnt_inc) wait_cnt <= wait_cnt + 1'b1;
  end

  // One-cycle response pulse; read data only on a successful read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= complete || abort;
      rsp_err   <= abort;
      rsp_rdata <= (complete && !w_en) ? data_bus : '0;
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: three masters (TIMEOUT 16/4/3) each against a
// behavioural bank with run-time latency and a stall switch.
module tb_mem_master;

  localparam int NI = 3;
  localparam int DW = 32;
  localparam int AW = 8;

  typedef struct {
    int unsigned   acc;
    int unsigned   due;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            err;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NI-1:0] req_valid, req_ready, req_we, rsp_valid, rsp_err;
  logic [NI-1:0] sel, w_en, mem_ready, commit_ev, stall;
  logic [AW-1:0] req_addr    [NI];
  logic [DW-1:0] req_wdata   [NI];
  logic [DW-1:0] rsp_rdata   [NI];
  logic [AW-1:0] address_bus [NI];
  logic [DW-1:0] dmon        [NI];
  int            lat         [NI];

  int unsigned ecnt   = 0;
  int          checks = 0;
  int          errors = 0;

  txn_t          cur        [NI];
  bit            pend       [NI];
  int unsigned   last_lat   [NI];
  int unsigned   last_done  [NI];
  logic          last_err   [NI];
  logic [DW-1:0] last_rdata [NI];
  logic [DW-1:0] mmem       [NI][256];
  logic [DW-1:0] rd_log [$];
  int unsigned   gap_log [$];
  bit            b2b_on   = 1'b0;
  int            ncommit0 = 0;

  bit            sv_we   [8];
  logic [AW-1:0] sv_addr [8];
  logic [DW-1:0] sv_data [8];

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  function automatic int to_of(input int i);
    return (i == 0) ? 16 : (i == 1) ? 4 : 3;
  endfunction

  function automatic bit released(input logic [DW-1:0] v);
    return (v === '0) || (v === {DW{1'bz}});
  endfunction

  for (genvar g = 0; g < NI; g++) begin : inst
    localparam int TO = (g == 0) ? 16 : (g == 1) ? 4 : 3;
    wire  [DW-1:0] dbus;
    logic [DW-1:0] bmem [256];
    logic          busy, armed, rdy;
    int            cnt;

    mem_master #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .rsp_err    (rsp_err[g]),
      .sel        (sel[g]),
      .w_en       (w_en[g]),
      .address_bus(address_bus[g]),
      .data_bus   (dbus),
      .mem_ready  (mem_ready[g])
    );

    assign dbus         = (sel[g] && !w_en[g]) ? bmem[address_bus[g]] : {DW{1'bz}};
    assign dmon[g]      = dbus;
    assign mem_ready[g] = rdy && !stall[g];
    assign commit_ev[g] = busy && (cnt == 0) && sel[g] && w_en[g] && !stall[g];

    initial for (int j = 0; j < 256; j++) bmem[j] = '0;

    // Bank: arms on sel low, counts down lat cycles, raises ready, commits writes.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        busy <= 1'b0; armed <= 1'b1; rdy <= 1'b0; cnt <= 0;
      end else if (!sel[g]) begin
        busy <= 1'b0; armed <= 1'b1; rdy <= 1'b0;
      end else if (armed) begin
        busy <= 1'b1; armed <= 1'b0; cnt <= lat[g];
      end else if (busy) begin
        if (cnt == 0) begin
          rdy  <= 1'b1;
          busy <= 1'b0;
          if (w_en[g] && !stall[g]) bmem[address_bus[g]] <= dbus;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d edge %0d: got 0x%0h, expected 0x%0h", nm, i, ecnt, act, exp);
    end
  endtask

  // Model: each accepted request completes L+3 edges later if L+2 <= TIMEOUT,
  // otherwise (or when the bank stalls) aborts TIMEOUT+1 edges later.
  task automatic compare_loop();
    logic [DW-1:0] exp_rd;
    int unsigned   d;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (rst) begin
          pend[i] = 1'b0;
          continue;
        end
        if (pend[i] && ecnt == cur[i].due) begin
          exp_rd = (cur[i].err || cur[i].we) ? '0 : mmem[i][cur[i].addr];
          chk("rsp_valid", i, rsp_valid[i], 1);
          chk("rsp_err", i, rsp_err[i], cur[i].err);
          chk("rsp_rdata", i, rsp_rdata[i], exp_rd);
          chk("sel_drop", i, sel[i], 0);
          if (cur[i].we && !cur[i].err) mmem[i][cur[i].addr] = cur[i].wdata;
          last_lat[i]   = ecnt - cur[i].acc;
          last_err[i]   = rsp_err[i];
          last_rdata[i] = rsp_rdata[i];
          last_done[i]  = ecnt;
          if (i == 0 && b2b_on && !cur[i].we) rd_log.push_back(rsp_rdata[0]);
          pend[i] = 1'b0;
        end else if (pend[i]) begin
          chk("rsp_idle", i, rsp_valid[i], 0);
          chk("sel_held", i, sel[i], 1);
          chk("w_en_held", i, w_en[i], cur[i].we);
          chk("addr_held", i, address_bus[i], cur[i].addr);
          if (cur[i].we) chk("bus_wdata", i, dmon[i], cur[i].wdata);
          else           chk("bus_rdata", i, dmon[i], mmem[i][cur[i].addr]);
        end else begin
          chk("rsp_idle", i, rsp_valid[i], 0);
          chk("sel_idle", i, sel[i], 0);
          chk("bus_release", i, released(dmon[i]), 1);
        end
        chk("commit", i, commit_ev[i], pend[i] && cur[i].we && !cur[i].err && (ecnt + 2 == cur[i].due));
        if (i == 0 && commit_ev[0]) ncommit0++;
        chk("req_ready", i, req_ready[i], !pend[i]);
        if (!pend[i] && req_valid[i]) begin
          d = (!stall[i] && lat[i] + 2 <= to_of(i)) ? lat[i] + 3 : to_of(i) + 1;
          cur[i].acc   = ecnt + 1;
          cur[i].due   = ecnt + 1 + d;
          cur[i].we    = req_we[i];
          cur[i].addr  = req_addr[i];
          cur[i].wdata = req_wdata[i];
          cur[i].err   = stall[i] || (lat[i] + 2 > to_of(i));
          if (i == 0 && b2b_on) gap_log.push_back(cur[i].acc - last_done[i]);
          pend[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic wait_ready(input int i);
    int n = 0;
    @(negedge clk);
    while (!req_ready[i] && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("ready_timeout", i, 0, 1);
  endtask

  task automatic wait_rsp(input int i);
    int n = 0;
    while (!rsp_valid[i] && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("rsp_timeout", i, 0, 1);
    #1;
  endtask

  task automatic single(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = a; req_wdata[i] = d;
    wait_ready(i);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    wait_rsp(i);
  endtask

  task automatic b2b(input int i, input int n);
    @(posedge clk); #1;
    req_valid[i] = 1'b1;
    for (int k = 0; k < n; k++) begin
      req_we[i] = sv_we[k]; req_addr[i] = sv_addr[k]; req_wdata[i] = sv_data[k];
      wait_ready(i);
      @(posedge clk); #1;
    end
    req_valid[i] = 1'b0;
    wait_rsp(i);
  endtask

  initial begin
    req_valid = '0; req_we = '0; stall = '0;
    for (int i = 0; i < NI; i++) begin
      req_addr[i] = '0; req_wdata[i] = '0; lat[i] = 2;
      pend[i] = 1'b0; last_done[i] = 0; last_lat[i] = 0;
      last_err[i] = 1'b0; last_rdata[i] = '0;
      for (int j = 0; j < 256; j++) mmem[i][j] = '0;
    end
    for (int k = 0; k < 4; k++) begin
      sv_we[k]   = 1'b1; sv_addr[k]   = AW'(k); sv_data[k]   = DW'(k + 1);
      sv_we[k+4] = 1'b0; sv_addr[k+4] = AW'(k); sv_data[k+4] = '0;
    end
    fork compare_loop(); join_none

    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_sel", i, sel[i], 0);
      chk("rst_w_en", i, w_en[i], 0);
      chk("rst_addr", i, address_bus[i], 0);
      chk("rst_rsp_valid", i, rsp_valid[i], 0);
      chk("rst_rsp_err", i, rsp_err[i], 0);
      chk("rst_rdata", i, rsp_rdata[i], 0);
      chk("rst_req_ready", i, req_ready[i], 1);
      chk("rst_bus", i, released(dmon[i]), 1);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Write then read, L = 2.
    single(0, 1'b1, 8'h10, 32'hDEADBEEF);
    chk("wr_lat", 0, last_lat[0], 5);
    chk("wr_err", 0, last_err[0], 0);
    single(0, 1'b0, 8'h10, '0);
    chk("rd_lat", 0, last_lat[0], 5);
    chk("rd_data", 0, last_rdata[0], 32'hDEADBEEF);

    // Back-to-back: four writes then four reads with req_valid held.
    b2b_on = 1'b1;
    b2b(0, 8);
    b2b_on = 1'b0;
    chk("b2b_reads", 0, rd_log.size(), 4);
    for (int k = 0; k < 4 && k < rd_log.size(); k++) chk("b2b_rd_val", 0, rd_log[k], k + 1);
    chk("b2b_txns", 0, gap_log.size(), 8);
    for (int k = 1; k < gap_log.size(); k++) chk("b2b_sel_gap", 0, gap_log[k], 1);

    // TIMEOUT = 4, L = 2: completes on the last allowed WAIT cycle.
    single(1, 1'b1, 8'h10, 32'hCAFE0001);
    single(1, 1'b0, 8'h10, '0);
    chk("to4_lat", 1, last_lat[1], 5);
    chk("to4_err", 1, last_err[1], 0);
    chk("to4_data", 1, last_rdata[1], 32'hCAFE0001);

    // TIMEOUT = 3: L = 2 aborts, L = 1 succeeds.
    lat[2] = 1;
    single(2, 1'b1, 8'h33, 32'h12345678);
    chk("to3_wr_err", 2, last_err[2], 0);
    lat[2] = 2;
    single(2, 1'b0, 8'h33, '0);
    chk("to3_abort_lat", 2, last_lat[2], 4);
    chk("to3_abort_err", 2, last_err[2], 1);
    chk("to3_abort_data", 2, last_rdata[2], 0);
    lat[2] = 1;
    single(2, 1'b0, 8'h33, '0);
    chk("to3_retry_err", 2, last_err[2], 0);
    chk("to3_retry_data", 2, last_rdata[2], 32'h12345678);

    // Bank never ready: abort TIMEOUT+1 edges after acceptance.
    stall[0] = 1'b1;
    single(0, 1'b0, 8'h10, '0);
    chk("stall_lat", 0, last_lat[0], 17);
    chk("stall_err", 0, last_err[0], 1);
    chk("stall_data", 0, last_rdata[0], 0);
    stall[0] = 1'b0;
    @(negedge clk);
    chk("stall_sel", 0, sel[0], 0);

    // Reset two cycles into a write to 0x20.
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 8'h20; req_wdata[0] = 32'h55;
    wait_ready(0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_drive", 0, dmon[0], 32'h55);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_sel", 0, sel[0], 0);
    chk("mid_rst_bus", 0, released(dmon[0]), 1);
    chk("mid_rst_rsp", 0, rsp_valid[0], 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    single(0, 1'b0, 8'h20, '0);
    chk("post_rst_err", 0, last_err[0], 0);
    chk("post_rst_data", 0, last_rdata[0], 0);
    chk("post_rst_commits", 0, ncommit0, 5);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
